// File: rtl/lsu_dram_master.sv
// lsu_dram_master: load/store initiator that splits misaligned accesses for a one-cycle-latency RAM port
module lsu_dram_master #(
  parameter bit ALLOW_MISALIGN = 1'b1,
  parameter int ADDR_BITS = 15
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_op,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);
  typedef enum logic [2:0] {IDLE, ST, RD_A, RD_B, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0] k, k_n, last, c_last, c_fmt;
  logic legal, mis, two, err, c_mis, c_two;
  logic [31:0] c_addr, c_wdata, lo_word, sh, merged;
  logic wr_n, rd_n, rv_n, re_n;
  logic [2:0] op_n;
  logic [31:0] addr_n, wdata_n, rdata_n;

  function automatic logic [31:0] wrap(input logic [31:0] a, input logic [31:0] inc);
    return {a[31:ADDR_BITS], a[ADDR_BITS-1:0] + inc[ADDR_BITS-1:0]};
  endfunction

  assign last  = req_op[1] ? 2'd3 : {1'b0, req_op[0]};
  assign legal = req_wr ? (req_op inside {3'b000, 3'b001, 3'b010})
                        : (req_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign mis   = (req_op[1:0] == 2'b01 && req_addr[0]) || (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign two   = ({1'b0, req_addr[1:0]} + {1'b0, last}) > 3'd3;
  assign err   = !legal || (mis && !ALLOW_MISALIGN);
  // little-endian merge of up to two fetched words, then extension by access size
  assign sh     = 32'({rdata, c_two ? lo_word : rdata} >> {c_addr[1:0], 3'b000});
  assign merged = c_fmt[0] ? sh : c_fmt[1] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};

  always_comb begin
    state_n = state;
    k_n = k;
    wr_n = 1'b0;
    rd_n = 1'b0;
    op_n = 3'b000;
    addr_n = '0;
    wdata_n = '0;
    rv_n = 1'b0;
    re_n = 1'b0;
    rdata_n = '0;
    case (state)
      IDLE, RESP: begin
        state_n = IDLE;
        if (req_valid) begin
          k_n = 2'd0;
          if (err) begin
            state_n = RESP;
            rv_n = 1'b1;
            re_n = 1'b1;
          end else if (req_wr) begin
            state_n = ST;
            wr_n = 1'b1;
            op_n = mis ? 3'b000 : req_op;
            addr_n = req_addr;
            wdata_n = mis ? {24'b0, req_wdata[7:0]} : req_wdata;
          end else begin
            state_n = RD_A;
            rd_n = 1'b1;
            op_n = mis ? 3'b010 : req_op;
            addr_n = mis ? {req_addr[31:2], 2'b00} : req_addr;
          end
        end
      end
      ST: begin
        if (k == c_last) begin
          state_n = RESP;
          rv_n = 1'b1;
        end else begin
          k_n = k + 2'd1;
          wr_n = 1'b1;
          addr_n = wrap(c_addr, {30'b0, k_n});
          wdata_n = {24'b0, c_wdata[{k_n, 3'b000} +: 8]};
        end
      end
      RD_A: begin
        state_n = c_two ? RD_B : WAIT;
        rd_n = c_two;
        op_n = c_two ? 3'b010 : 3'b000;
        addr_n = c_two ? wrap({c_addr[31:2], 2'b00}, 32'd4) : '0;
      end
      RD_B: state_n = WAIT;
      WAIT: begin
        state_n = RESP;
        rv_n = 1'b1;
        rdata_n = c_mis ? merged : rdata;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
      mem_op <= 3'b000;
      addr <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      req_ready <= state_n == IDLE || state_n == RESP;
      rsp_valid <= rv_n;
      rsp_err <= re_n;
      rsp_rdata <= rdata_n;
      mem_wr <= wr_n;
      mem_rd <= rd_n;
      mem_op <= op_n;
      addr <= addr_n;
      wdata <= wdata_n;
    end
  end

  always_ff @(posedge sclk) begin
    if (req_valid && req_ready) begin
      c_addr <= req_addr;
      c_wdata <= req_wdata;
      c_fmt <= {req_op[2], req_op[1]};
      c_mis <= mis;
      c_two <= mis && two;
      c_last <= mis ? last : 2'd0;
    end
    if (state == RD_B) lo_word <= rdata;
  end
endmodule
